// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared types and helpers for the Simon input path
package simon_pkg;
  localparam int NUM_BUTTONS = 4;
  localparam int BTN_IDX_W = $clog2(NUM_BUTTONS);
  localparam int DEFAULT_TIMEOUT_CYCLES = 250_000_000;

  typedef logic [BTN_IDX_W-1:0] btn_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    HELD,
    REPORT,
    TIMED_OUT
  } arb_state_t;

  // Fixed priority: scanning downward lets the lowest set bit win.
  function automatic btn_idx_t lowest_index(input logic [NUM_BUTTONS-1:0] vec);
    btn_idx_t idx;
    idx = '0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (vec[i]) idx = btn_idx_t'(i);
    end
    return idx;
  endfunction
endpackage

// File: rtl/simon_inactivity_timer.sv
// rtl/simon_inactivity_timer.sv - saturating inactivity counter
// with a registered one-cycle expiry pulse.
module simon_inactivity_timer
  import simon_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic limit,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  assign limit = (count == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      expired <= 1'b0;
    end else begin
      expired <= !clear && count_en && limit;
      if (clear) begin
        count <= '0;
      end else if (count_en && !limit) begin
        count <= count + 1'b1;
      end
    end
  end
endmodule

// File: rtl/simon_input_arbiter.sv
// rtl/simon_input_arbiter.sv - grants one Simon button at a time and
// reports each move on release through a valid/ready handshake.
module simon_input_arbiter #(
  parameter int NUM_BUTTONS    = simon_pkg::NUM_BUTTONS,
  parameter int TIMEOUT_CYCLES = simon_pkg::DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [NUM_BUTTONS-1:0]         held,
  input  logic [NUM_BUTTONS-1:0]         pressed,
  output logic                           evt_valid,
  input  logic                           evt_ready,
  output logic [$clog2(NUM_BUTTONS)-1:0] evt_button,
  output logic [NUM_BUTTONS-1:0]         lamp,
  output logic                           timeout,
  output logic                           busy
);
  import simon_pkg::*;

  arb_state_t state, next_state;
  btn_idx_t   idx, next_idx;
  logic       count_en, clear, limit;

  simon_inactivity_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .count_en(count_en),
    .limit   (limit),
    .expired (timeout)
  );

  assign clear      = (state != ARMED);
  assign evt_button = idx;

  always_comb begin
    next_state = state;
    next_idx   = idx;
    count_en   = 1'b0;
    case (state)
      IDLE: begin
        if (enable && held == '0) next_state = ARMED;
      end
      ARMED: begin
        if (!enable) begin
          next_state = IDLE;
        end else if (|pressed) begin
          // A press beats a timeout landing in the same cycle.
          next_state = HELD;
          next_idx   = lowest_index(pressed);
        end else begin
          count_en = 1'b1;
          if (limit) next_state = TIMED_OUT;
        end
      end
      HELD: begin
        if (!enable) next_state = IDLE;
        else if (held == '0) next_state = REPORT;
      end
      REPORT: begin
        if (evt_valid && evt_ready) next_state = ARMED;
      end
      TIMED_OUT: begin
        if (!enable) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      lamp      <= '0;
      evt_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= next_state;
      idx       <= next_idx;
      lamp      <= (next_state == HELD) ? (NUM_BUTTONS'(1) << next_idx) : '0;
      evt_valid <= (next_state == REPORT);
      busy      <= (next_state == HELD) || (next_state == REPORT);
    end
  end
endmodule

// File: tb/tb_simon_input_arbiter.sv
// tb/tb_simon_input_arbiter.sv - directed and random checks of the
// Simon input arbiter against a behavioural model.
module tb_simon_input_arbiter;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       reset, enable, evt_ready;
  logic [3:0] held, pressed;
  logic       evt_valid, timeout, busy;
  logic [1:0] evt_button;
  logic [3:0] lamp;

  int n_vec = 0;
  int n_bad = 0;

  // Model: the move currently granted (-1 none), whether a move awaits
  // acceptance, whether the player is being watched for inactivity, etc.
  int m_grant, m_btn, m_quiet;
  bit m_pend, m_watch, m_stall, m_to;

  always #5 clk = ~clk;

  simon_input_arbiter #(.NUM_BUTTONS(4), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .enable(enable), .held(held), .pressed(pressed),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_button(evt_button),
    .lamp(lamp), .timeout(timeout), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    m_to = 1'b0;
    if (reset) begin
      m_grant = -1; m_btn = 0; m_quiet = 0;
      m_pend = 0; m_watch = 0; m_stall = 0;
    end else if (m_pend) begin
      if (evt_ready) begin m_pend = 0; m_watch = 1; m_quiet = 0; end
    end else if (m_grant >= 0) begin
      if (!enable) m_grant = -1;
      else if (held == 4'b0) begin m_pend = 1; m_grant = -1; end
    end else if (m_stall) begin
      if (!enable) m_stall = 0;
    end else if (m_watch) begin
      if (!enable) m_watch = 0;
      else if (pressed != 4'b0) begin
        m_grant = lowest(pressed); m_btn = m_grant; m_watch = 0;
      end else if (m_quiet == T - 1) begin
        m_stall = 1; m_to = 1; m_watch = 0;
      end else m_quiet++;
    end else if (enable && held == 4'b0) begin
      m_watch = 1; m_quiet = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("lamp", lamp, (m_grant >= 0) ? (32'd1 << m_grant) : 32'd0);
    check("evt_valid", evt_valid, m_pend);
    check("evt_button", evt_button, m_btn);
    check("busy", busy, (m_grant >= 0) || m_pend);
    check("timeout", timeout, m_to);
  endtask

  task automatic drive(input logic r, input logic e, input logic [3:0] h,
                       input logic [3:0] p, input logic rdy);
    reset = r; enable = e; held = h; pressed = p; evt_ready = rdy;
  endtask

  initial begin
    int pulses, pulse_at;
    logic [3:0] hv, nv;
    bit quiet_phase;

    drive(1, 0, 0, 0, 0);
    cycle();
    check("rst_valid", evt_valid, 0);
    check("rst_lamp", lamp, 0);

    // Single press of button 2
    drive(0, 1, 0, 0, 1); cycle();
    drive(0, 1, 4'b0100, 4'b0100, 1); cycle();
    check("t1_lamp", lamp, 4'b0100);
    drive(0, 1, 4'b0100, 0, 1);
    for (int i = 0; i < 9; i++) cycle();
    drive(0, 1, 0, 0, 1); cycle();
    check("t1_valid", evt_valid, 1);
    check("t1_button", evt_button, 2);
    check("t1_lamp_off", lamp, 0);
    cycle();
    check("t1_valid_drop", evt_valid, 0);

    // Simultaneous press, then a second button mid-hold
    drive(0, 1, 4'b1010, 4'b1010, 1); cycle();
    check("t2_lamp", lamp, 4'b0010);
    drive(0, 1, 4'b1010, 0, 1); cycle(); cycle();
    drive(0, 1, 4'b1000, 0, 1); cycle();
    drive(0, 1, 4'b1100, 4'b0100, 1); cycle();
    check("t2_lamp_keep", lamp, 4'b0010);
    drive(0, 1, 4'b1100, 0, 1); cycle();
    drive(0, 1, 0, 0, 1); cycle();
    check("t2_button", evt_button, 1);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin cycle(); pulses += evt_valid; end
    check("t2_no_second", pulses, 0);

    // Back-pressured event with a press during the wait
    drive(0, 1, 4'b0001, 4'b0001, 0); cycle();
    drive(0, 1, 0, 0, 0); cycle();
    for (int i = 0; i < 20; i++) begin
      if (i == 5) drive(0, 1, 4'b1000, 4'b1000, 0);
      else if (i == 6) drive(0, 1, 4'b1000, 0, 0);
      else if (i == 8) drive(0, 1, 0, 0, 0);
      cycle();
      check("t3_hold_valid", evt_valid, 1);
      check("t3_hold_button", evt_button, 0);
    end
    drive(0, 1, 0, 0, 1); cycle();
    check("t3_accept", evt_valid, 0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin cycle(); pulses += evt_valid; end
    check("t3_no_event", pulses, 0);

    // Inactivity timeout
    drive(1, 0, 0, 0, 1); cycle();
    drive(0, 1, 0, 0, 1); cycle();
    pulses = 0; pulse_at = -1;
    for (int k = 1; k <= 30; k++) begin
      cycle();
      if (timeout) begin pulses++; pulse_at = k; end
    end
    check("t4_pulses", pulses, 1);
    check("t4_pulse_at", pulse_at, 16);
    drive(0, 1, 4'b0010, 4'b0010, 1); cycle();
    check("t4_stuck", lamp, 0);
    drive(0, 0, 0, 0, 1); cycle(); cycle();

    // Enable dropped in HELD, reset in REPORT
    drive(0, 1, 0, 0, 1); cycle();
    drive(0, 1, 4'b0001, 4'b0001, 1); cycle();
    check("t5_lamp", lamp, 4'b0001);
    drive(0, 0, 4'b0001, 0, 1); cycle();
    check("t5_lamp_off", lamp, 0);
    check("t5_busy", busy, 0);
    drive(0, 0, 0, 0, 1); cycle();
    check("t5_no_event", evt_valid, 0);
    drive(0, 1, 0, 0, 0); cycle();
    drive(0, 1, 4'b0100, 4'b0100, 0); cycle();
    drive(0, 1, 0, 0, 0); cycle();
    check("t5_pending", evt_valid, 1);
    drive(1, 1, 0, 0, 0); cycle();
    check("t5_rst_drop", evt_valid, 0);

    // Button already held when enable rises
    drive(0, 1, 4'b0001, 0, 1);
    for (int i = 0; i < 4; i++) cycle();
    drive(0, 1, 4'b0101, 4'b0100, 1); cycle();
    check("t6_still_idle", lamp, 0);
    drive(0, 1, 0, 0, 1); cycle();
    drive(0, 1, 4'b0010, 4'b0010, 1); cycle();
    check("t6_armed_lamp", lamp, 4'b0010);

    // Random traffic
    hv = 4'b0010;
    quiet_phase = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 0) quiet_phase = ~quiet_phase;
      nv = hv;
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, quiet_phase ? 63 : 7) == 0) nv[b] = ~nv[b];
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 63) == 0) enable = ~enable;
      evt_ready = ($urandom_range(0, 3) != 0);
      pressed = nv & ~hv;
      held = nv;
      hv = nv;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
